// File: rtl/neuron_core_pkg.sv
// Shared types and constants for the SNN neuron core.
package neuron_core_pkg;

   localparam int NUM_NEURONS_DEF = 256;
   localparam int NUM_AXONS_DEF   = 256;
   localparam int POT_W           = 8;

   // syn_rdata = {connected, weight_sel[1:0]}
   localparam int CONN_BIT = 2;
   localparam int WSEL_LSB = 0;

   typedef enum logic [1:0] {
      WSEL_T1 = 2'd0,
      WSEL_T2 = 2'd1,
      WSEL_T3 = 2'd2,
      WSEL_T4 = 2'd3
   } wsel_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_RD,
      S_LOAD,
      S_INTEG,
      S_DRAIN,
      S_FIRE,
      S_WB,
      S_DONE
   } state_e;

endpackage

// File: rtl/neuron_timestep_ctrl.sv
// Timestep sequencer: per neuron load potential, integrate all axons,
// fire, write back, record spike.
module neuron_timestep_ctrl
   import neuron_core_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int NUM_AXONS   = NUM_AXONS_DEF,
   localparam int NW = $clog2(NUM_NEURONS),
   localparam int AW = $clog2(NUM_AXONS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start_i,
   input  logic [NUM_AXONS-1:0]   axon_spikes_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [NUM_NEURONS-1:0] spike_out_o,
   output logic                   syn_rd_o,
   output logic [NW+AW-1:0]       syn_addr_o,
   input  logic [2:0]             syn_rdata_i,
   output logic                   pot_rd_o,
   output logic                   pot_we_o,
   output logic [NW-1:0]          pot_addr_o,
   output logic [POT_W-1:0]       pot_wdata_o,
   input  logic [POT_W-1:0]       pot_rdata_i,
   output logic                   dp_load_o,
   output logic [POT_W-1:0]       dp_potential_o,
   output logic                   dp_acc_o,
   output logic [1:0]             dp_weight_sel_o,
   output logic                   dp_fire_o,
   input  logic                   dp_valid_i,
   input  logic [POT_W-1:0]       dp_result_i,
   input  logic                   dp_spike_i
);

   state_e                 state_q, state_d;
   logic [NW-1:0]          n_q;
   logic [AW-1:0]          a_q;
   logic [AW-1:0]          a_prev_q;
   logic [NUM_AXONS-1:0]   spikes_q;
   logic [NUM_NEURONS-1:0] spike_out_q;
   logic                   acc_win;
   logic                   a_last;
   logic                   n_last;

   assign a_last      = (a_q == AW'(NUM_AXONS - 1));
   assign n_last      = (n_q == NW'(NUM_NEURONS - 1));
   assign busy_o      = (state_q != S_IDLE);
   assign spike_out_o = spike_out_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      acc_win         = 1'b0;
      done_o          = 1'b0;
      syn_rd_o        = 1'b0;
      syn_addr_o      = '0;
      pot_rd_o        = 1'b0;
      pot_we_o        = 1'b0;
      pot_addr_o      = '0;
      pot_wdata_o     = '0;
      dp_load_o       = 1'b0;
      dp_potential_o  = '0;
      dp_fire_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_LOAD_RD;
         end
         S_LOAD_RD: begin
            pot_rd_o   = 1'b1;
            pot_addr_o = n_q;
            state_d    = S_LOAD;
         end
         S_LOAD: begin
            dp_load_o      = 1'b1;
            dp_potential_o = pot_rdata_i;
            state_d        = S_INTEG;
         end
         S_INTEG: begin
            syn_rd_o   = 1'b1;
            syn_addr_o = {n_q, a_q};
            acc_win    = (a_q != '0);
            if (a_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            acc_win = 1'b1;
            state_d = S_FIRE;
         end
         S_FIRE: begin
            dp_fire_o = 1'b1;
            state_d   = S_WB;
         end
         S_WB: begin
            if (dp_valid_i) begin
               pot_we_o    = 1'b1;
               pot_addr_o  = n_q;
               pot_wdata_o = dp_result_i;
               state_d     = n_last ? S_DONE : S_LOAD_RD;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // synapse data lags its read by one cycle, so gate with the previous axon
   always_comb begin
      dp_acc_o        = 1'b0;
      dp_weight_sel_o = '0;
      if (acc_win) begin
         dp_acc_o        = syn_rdata_i[CONN_BIT] & spikes_q[a_prev_q];
         dp_weight_sel_o = syn_rdata_i[WSEL_LSB +: 2];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_q         <= '0;
         a_q         <= '0;
         a_prev_q    <= '0;
         spikes_q    <= '0;
         spike_out_q <= '0;
      end else begin
         if (state_q == S_IDLE && start_i) begin
            spikes_q    <= axon_spikes_i;
            spike_out_q <= '0;
            n_q         <= '0;
            a_q         <= '0;
         end
         if (state_q == S_INTEG) begin
            a_prev_q <= a_q;
            a_q      <= a_last ? '0 : a_q + 1'b1;
         end
         if (state_q == S_WB && dp_valid_i) begin
            spike_out_q[n_q] <= dp_spike_i;
            n_q              <= n_last ? '0 : n_q + 1'b1;
         end
      end
   end

endmodule
